// File: rtl/aes_share_streamer.sv
// Host-side share streamer for a byte-serial two-share masked AES core.
// Loads 128-bit shares, streams re-masked byte pairs, collects 16-bit ciphertext words.
module aes_share_streamer #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [127:0] pt0,
  input  logic [127:0] pt1,
  input  logic [127:0] k0,
  input  logic [127:0] k1,
  input  logic [7:0]   random,
  output logic         ready,
  output logic [127:0] ct0,
  output logic [127:0] ct1,
  output logic         ct_valid,
  output logic         err,
  output logic [7:0]   core_plain0,
  output logic [7:0]   core_plain1,
  output logic [7:0]   core_key0,
  output logic [7:0]   core_key1,
  output logic         core_pk_valid,
  input  logic [15:0]  core_cipher0,
  input  logic [15:0]  core_cipher1,
  input  logic         core_done,
  input  logic         core_busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, RESULT} state_t;

  state_t         state, state_nx;
  logic [127:0]   sh_pt0, sh_pt1, sh_k0, sh_k1;
  logic [127:0]   col0, col1;
  logic [3:0]     byte_cnt;
  logic [2:0]     word_cnt;
  logic [TW-1:0]  to_cnt;
  logic           waiting, cap, tout;

  assign waiting = (state == WAIT) || (state == COLLECT);
  assign cap     = waiting && core_done;
  // A word arriving on the last allowed cycle still counts; abort only when idle-waiting.
  assign tout    = waiting && !core_done && (to_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !core_busy) state_nx = LOAD;
      LOAD:    if (byte_cnt == 4'd15) state_nx = WAIT;
      WAIT:    if (core_done) state_nx = COLLECT;
               else if (tout) state_nx = IDLE;
      COLLECT: if (core_done && word_cnt == 3'd7) state_nx = RESULT;
               else if (tout) state_nx = IDLE;
      RESULT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ready         <= 1'b1;
      ct0           <= '0;
      ct1           <= '0;
      ct_valid      <= 1'b0;
      err           <= 1'b0;
      core_plain0   <= '0;
      core_plain1   <= '0;
      core_key0     <= '0;
      core_key1     <= '0;
      core_pk_valid <= 1'b0;
      sh_pt0        <= '0;
      sh_pt1        <= '0;
      sh_k0         <= '0;
      sh_k1         <= '0;
      col0          <= '0;
      col1          <= '0;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      to_cnt        <= '0;
    end else begin
      state    <= state_nx;
      // Outputs trail the state by one edge; ready also rises with the RESULT pulse.
      ready    <= (state == IDLE) || (state_nx == IDLE);
      ct_valid <= (state == RESULT);
      err      <= tout;

      if (state == IDLE && state_nx == LOAD) begin
        sh_pt0   <= pt0;
        sh_pt1   <= pt1;
        sh_k0    <= k0;
        sh_k1    <= k1;
        byte_cnt <= '0;
        word_cnt <= '0;
      end

      if (state == LOAD) begin
        // Same fresh byte on every share keeps each unmasked value intact.
        core_plain0   <= sh_pt0[127:120] ^ random;
        core_plain1   <= sh_pt1[127:120] ^ random;
        core_key0     <= sh_k0[127:120] ^ random;
        core_key1     <= sh_k1[127:120] ^ random;
        core_pk_valid <= 1'b1;
        sh_pt0        <= {sh_pt0[119:0], 8'h00};
        sh_pt1        <= {sh_pt1[119:0], 8'h00};
        sh_k0         <= {sh_k0[119:0], 8'h00};
        sh_k1         <= {sh_k1[119:0], 8'h00};
        byte_cnt      <= byte_cnt + 4'd1;
      end else begin
        core_plain0   <= '0;
        core_plain1   <= '0;
        core_key0     <= '0;
        core_key1     <= '0;
        core_pk_valid <= 1'b0;
      end

      if (state == LOAD || cap)
        to_cnt <= '0;
      else if (waiting)
        to_cnt <= to_cnt + 1'b1;

      if (cap) begin
        col0     <= {col0[111:0], core_cipher0};
        col1     <= {col1[111:0], core_cipher1};
        word_cnt <= word_cnt + 3'd1;
      end

      if (state == RESULT) begin
        ct0 <= col0;
        ct1 <= col1;
      end
    end
  end

endmodule

// File: tb/tb_aes_share_streamer.sv
// Randomized bench: a behavioural masked-core stand-in computes real AES-128 from the
// unmasked streamed bytes and returns random ciphertext shares with configurable gaps.
module tb_aes_share_streamer;
  localparam int TO = 32;
  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [127:0] pt0 = '0, pt1 = '0, k0 = '0, k1 = '0;
  logic [7:0]   random = '0;
  logic         ready, ct_valid, err, core_pk_valid;
  logic [127:0] ct0, ct1;
  logic [7:0]   core_plain0, core_plain1, core_key0, core_key1;
  logic [15:0]  core_cipher0 = '0, core_cipher1 = '0;
  logic         core_done = 1'b0, core_busy = 1'b0;

  int checks = 0, errors = 0, ctv_cnt = 0, err_cnt = 0;
  logic [127:0] m_ct0 = '0, m_ct1 = '0;

  always #5 clk = ~clk;

  aes_share_streamer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .pt0(pt0), .pt1(pt1), .k0(k0), .k1(k1), .random(random),
    .ready(ready), .ct0(ct0), .ct1(ct1), .ct_valid(ct_valid), .err(err),
    .core_plain0(core_plain0), .core_plain1(core_plain1),
    .core_key0(core_key0), .core_key1(core_key1), .core_pk_valid(core_pk_valid),
    .core_cipher0(core_cipher0), .core_cipher1(core_cipher1),
    .core_done(core_done), .core_busy(core_busy)
  );

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk128(name, {120'b0, act}, {120'b0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk128(name, {127'b0, act}, {127'b0, exp});
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    chk128(name, {96'b0, act}, {96'b0, exp});
  endtask

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16], t[16], rk[176], tmp[4];
    logic [7:0] rc, a0, a1, a2, a3, sv;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      s[i]  = pt[127-8*i -: 8] ^ rk[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
      if (i % 16 == 0) begin
        sv = tmp[0];
        tmp[0] = sbox(tmp[1]) ^ rc;
        tmp[1] = sbox(tmp[2]);
        tmp[2] = sbox(tmp[3]);
        tmp[3] = sbox(sv);
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[16*rd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (ct_valid) ctv_cnt++;
      if (err) err_cnt++;
      if (!ct_valid) begin
        chk128("ct0_hold", ct0, m_ct0);
        chk128("ct1_hold", ct1, m_ct1);
      end
      chk1("pkv_while_ready", core_pk_valid & ready, 1'b0);
      chk1("err_with_ctv", err & ct_valid, 1'b0);
    end
  end

  task automatic check_reset(input string tag);
    chk1({tag, "_ready"}, ready, 1'b1);
    chk1({tag, "_ctv"}, ct_valid, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_pkv"}, core_pk_valid, 1'b0);
    chk128({tag, "_ct0"}, ct0, '0);
    chk128({tag, "_ct1"}, ct1, '0);
    chk8({tag, "_p0"}, core_plain0, 8'h00);
    chk8({tag, "_p1"}, core_plain1, 8'h00);
    chk8({tag, "_k0"}, core_key0, 8'h00);
    chk8({tag, "_k1"}, core_key1, 8'h00);
  endtask

  // mode: 0 back-to-back words, 1 gap of 6 after word 3, 2 no words (timeout), 3 random gaps
  task automatic run_txn(input logic [127:0] pt, input logic [127:0] k, input int mode,
                         input bit fix_rnd, input bit hold, input int rst_at);
    logic [127:0] c, c0, c1, ptr, kr;
    logic [7:0]   rb;
    int ctv0, err0, n, d, w, last;
    int st[8];
    pt1 = rand128(); pt0 = pt ^ pt1;
    k1  = rand128(); k0  = k ^ k1;
    ptr = '0; kr = '0;
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    chk1("ready_before_start", ready, 1'b1);
    ctv0 = ctv_cnt; err0 = err_cnt;
    core_busy = 1'b0; start = 1'b1;
    core_done = 1'($urandom_range(0, 1)); core_cipher0 = 16'($urandom); core_cipher1 = 16'($urandom);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk1("edge0_ready", ready, 1'b1);
    chk1("edge0_pkv", core_pk_valid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rb = fix_rnd ? 8'hA5 : 8'($urandom);
      random = rb;
      core_done = 1'($urandom_range(0, 1)); core_cipher0 = 16'($urandom); core_cipher1 = 16'($urandom);
      @(negedge clk);
      chk1("load_pkv", core_pk_valid, 1'b1);
      chk1("load_ready", ready, 1'b0);
      chk8("plain0_mask", core_plain0, pt0[127-8*i -: 8] ^ rb);
      chk8("key1_mask", core_key1, k1[127-8*i -: 8] ^ rb);
      chk8("plain_unmasked", core_plain0 ^ core_plain1, pt[127-8*i -: 8]);
      chk8("key_unmasked", core_key0 ^ core_key1, k[127-8*i -: 8]);
      ptr[127-8*i -: 8] = core_plain0 ^ core_plain1;
      kr[127-8*i -: 8]  = core_key0 ^ core_key1;
      if (i == rst_at) begin
        #2 rstn = 1'b0;
        #1 check_reset("midreset");
        m_ct0 = '0; m_ct1 = '0;
        core_done = 1'b0; start = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        return;
      end
    end
    core_done = 1'b0;
    @(negedge clk);
    chk1("wait_pkv", core_pk_valid, 1'b0);
    c = aes128(ptr, kr); c1 = rand128(); c0 = c ^ c1;
    if (mode == 2) begin
      for (int t = 18; t <= 16 + TO; t++) begin
        core_cipher0 = 16'($urandom);
        @(negedge clk);
        chk1("timeout_err", err, t == 16 + TO);
        chk1("timeout_no_ctv", ct_valid, 1'b0);
      end
      @(negedge clk);
      chk1("timeout_err_pulse", err, 1'b0);
      chk1("timeout_ready", ready, 1'b1);
      chk32("timeout_err_count", err_cnt - err0, 1);
      chk32("timeout_ctv_count", ctv_cnt - ctv0, 0);
      return;
    end
    d = $urandom_range(0, 5);
    repeat (d) begin
      core_cipher0 = 16'($urandom);
      @(negedge clk);
      chk1("wait_no_ctv", ct_valid, 1'b0);
    end
    n = 0;
    for (int j = 0; j < 8; j++) begin
      st[j] = n;
      n += 1 + ((mode == 1 && j == 3) ? 6 : (mode == 3 ? int'($urandom_range(0, 3)) : 0));
    end
    last = st[7]; w = 0;
    for (int t = 0; t <= last; t++) begin
      if (t == st[w]) begin
        core_done = 1'b1;
        core_cipher0 = c0[127-16*w -: 16];
        core_cipher1 = c1[127-16*w -: 16];
        w++;
      end else begin
        core_done = 1'b0;
        core_cipher0 = 16'($urandom); core_cipher1 = 16'($urandom);
      end
      @(negedge clk);
      chk1("collect_no_ctv", ct_valid, 1'b0);
      chk1("collect_no_err", err, 1'b0);
    end
    core_done = 1'b0;
    @(negedge clk);
    chk1("result_ctv", ct_valid, 1'b1);
    chk1("result_ready", ready, 1'b1);
    chk128("result_ct0", ct0, c0);
    chk128("result_ct1", ct1, c1);
    chk128("result_plain_ct", ct0 ^ ct1, aes128(pt, k));
    m_ct0 = c0; m_ct1 = c1;
    if (hold) core_busy = 1'b1;
    @(negedge clk);
    chk1("ctv_single_pulse", ct_valid, 1'b0);
    chk32("ctv_count", ctv_cnt - ctv0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");
    #2 rstn = 1'b1;
    @(negedge clk);
    check_reset("post_release");

    chk8("model_sbox00", sbox(8'h00), 8'h63);
    chk8("model_sbox53", sbox(8'h53), 8'hed);
    chk128("model_fips", aes128(FPT, FK), FCT);

    run_txn(FPT, FK, 0, 1'b0, 1'b0, -1);
    chk128("fips_ct", ct0 ^ ct1, FCT);

    run_txn(rand128(), rand128(), 0, 1'b1, 1'b0, -1);
    run_txn(rand128(), rand128(), 1, 1'b0, 1'b0, -1);
    run_txn(rand128(), rand128(), 2, 1'b0, 1'b0, -1);
    for (int r = 0; r < 4; r++)
      run_txn(rand128(), rand128(), (r % 2 == 0) ? 3 : 1, 1'b0, 1'b0, -1);

    run_txn(rand128(), rand128(), 0, 1'b0, 1'b1, -1);
    repeat (6) begin
      @(negedge clk);
      chk1("busy_no_load", core_pk_valid, 1'b0);
      chk1("busy_ready", ready, 1'b1);
    end
    run_txn(rand128(), rand128(), 3, 1'b0, 1'b0, -1);

    run_txn(rand128(), rand128(), 0, 1'b0, 1'b0, 7);
    @(negedge clk);
    check_reset("after_midreset");
    run_txn(rand128(), rand128(), 1, 1'b0, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
